rvfi_commit_checker: RTL and testbench
======================================

# rvfi_commit_checker

Parametrised, cycle-accurate commit-stream checker that sits beside the RVFI monitor on the retire ports of the out-of-order core. It accepts up to CHANNELS retirements per cycle and performs the following checks:
- channel packing and global order continuity;
- halt detection, and commits after halt;
- a no-commit watchdog;
- segment IPC counting via marker instructions.

Results are exposed as registered status outputs, so the checker can run in simulation or be bound into FPGA debug.

## Interface
Parameters:
- CHANNELS, 8, retire channels per cycle (1..16)
- ORDER_W, 64, width of order field
- CNT_W, 64, width of instruction/cycle counters
- TIMEOUT, 100000, consecutive no-commit cycles that trip the watchdog (≥2)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid  in  CHANNELS  per-channel retire valid
- order  in  CHANNELS×ORDER_W  per-channel retire order
- inst  in  CHANNELS×32  per-channel instruction word
- pc_rdata  in  CHANNELS×32  per-channel PC of instruction
- pc_wdata  in  CHANNELS×32  per-channel next PC
- halt  out  1  sticky, core has retired a halt instruction
- error  out  1  sticky, any check failed
- err_code  out  3  first error recorded: 0 none, 1 gap, 2 order, 3 post-halt, 4 timeout
- seg_state  out  2  segment FSM: 0 IDLE, 1 RUN, 2 DONE
- seg_inst_count  out  CNT_W  instructions retired in segment
- seg_cycle_count  out  CNT_W  cycles elapsed in segment
- commit_total  out  CNT_W  all counted retirements since reset

## Operation
- Channels are processed in ascending index order within a cycle.
- The effective set is valid[0..h], where h is the first halting channel, or the last channel if none halts.
- Channels above h are excluded from counts and checks.

Halt detection:
- Halt condition: pc_rdata==pc_wdata, or inst is one of 0x00000063, 0x0000006f, 0xF0002013.
- The first valid halting channel sets halt.

Checks:
- Gap: valid[i] & ~valid[i-1] for any i≥1 within the effective set sets error with code 1.
- Order: an expected register E starts at 0 after reset.
  - The k-th effective valid channel must carry order == E+k (k from 0); a mismatch gives code 2.
  - E advances by the effective valid count every cycle, even if a mismatch occurred.
- Post-halt: any valid in a cycle after halt is set gives code 3. Such commits are not counted.
- Watchdog: the idle counter increments on cycles with no valid, clears on any valid, and reaches TIMEOUT gives code 4.
  - It saturates and stops once halt=1.

Error recording:
- error and err_code are sticky until rst.
- err_code captures only the first error. If several fire in the same cycle, the lowest code wins.

Segment FSM:
- IDLE→RUN on a start marker 0x00102013: counters clear, and only effective channels above the marker in that cycle are counted.
- RUN→DONE on a stop marker 0x00202013: the stop marker and channels below it are counted, channels above it are not, and counters freeze.
- A start marker in DONE or RUN restarts RUN (counters clear).
- A stop marker in IDLE or DONE is ignored.
- Start and stop in the same cycle: resolve in channel order (start at lower index, then stop gives DONE with the between-channels plus stop counted).

seg_cycle_count behaviour:
- It is 0 after the start cycle.
- It increments by 1 on every subsequent RUN cycle, including the stop cycle.

commit_total:
- Adds the effective valid count every cycle, excluding post-halt commits.

Widths:
- All counters wrap modulo 2^CNT_W.
- E wraps modulo 2^ORDER_W, and order compare is modulo.

## Timing
- All outputs are registered. The effect of inputs in cycle n is visible after the clk edge ending cycle n (1-cycle latency).
- Reset values: halt=0, error=0, err_code=0, seg_state=IDLE, seg_inst_count=0, seg_cycle_count=0, commit_total=0. Internal E=0 and idle counter=0.
- rst asserted mid-segment or mid-error clears everything on that edge; inputs in the rst cycle are ignored.
- The watchdog trips on the edge that makes TIMEOUT consecutive idle cycles, i.e. error is visible after exactly TIMEOUT idle cycles.
- No handshake: the checker never back-pressures; inputs are sampled every non-reset cycle.

## Test plan
- Counting and order: CHANNELS=8. Retire 3 packed commits (orders 0,1,2) then 8 (orders 3..10) → no error, commit_total=11.
- Gap: valid=8'b0000_0101 with orders 0,1 → error=1, err_code=1 one cycle later.
- Order mismatch: orders 0,1 then 3 → err_code=2. A later gap leaves err_code at 2.
- Segment accounting: start marker on channel 2 with channels 0–4 valid, then 4 idle cycles, then 5 commits with stop marker on channel 3 of 5 → seg_state=DONE, seg_inst_count=2+4=6, seg_cycle_count=5.
- Halt handling: inst 0x0000006f on channel 1 with channels 0–3 valid → halt=1, commit_total+=2. A valid in the next cycle gives err_code=3.
- Watchdog and reset: TIMEOUT=16, no commits for 16 cycles → err_code=4 at cycle 16, not at 15. Assert rst → all outputs return to reset values.

Source files
------------

// File: rtl/rvfi_commit_checker_if.sv
// Retire-port bundle of the out-of-order core: up to CHANNELS retirements per
// cycle, channel 0 being the oldest instruction.
interface rvfi_commit_checker_if #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned ORDER_W  = 64
);
  logic [CHANNELS-1:0]              valid;
  logic [CHANNELS-1:0][ORDER_W-1:0] order;
  logic [CHANNELS-1:0][31:0]        inst;
  logic [CHANNELS-1:0][31:0]        pc_rdata;
  logic [CHANNELS-1:0][31:0]        pc_wdata;

  modport master (output valid, order, inst, pc_rdata, pc_wdata);
  modport slave  (input  valid, order, inst, pc_rdata, pc_wdata);
endinterface

// File: rtl/rvfi_commit_checker.sv
// Commit-stream checker for the retire ports: packing/order continuity, halt
// and post-halt commits, no-commit watchdog, and marker-delimited segment
// instruction/cycle counting. All status outputs are registered.
module rvfi_commit_checker #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned ORDER_W  = 64,
  parameter int unsigned CNT_W    = 64,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  rvfi_commit_checker_if.slave rvfi,
  output logic                 halt,
  output logic                 error,
  output logic [2:0]           err_code,
  output logic [1:0]           seg_state,
  output logic [CNT_W-1:0]     seg_inst_count,
  output logic [CNT_W-1:0]     seg_cycle_count,
  output logic [CNT_W-1:0]     commit_total
);

  localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned       VCNT_W    = $clog2(CHANNELS + 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT);

  localparam logic [31:0] INST_START  = 32'h0010_2013;
  localparam logic [31:0] INST_STOP   = 32'h0020_2013;
  localparam logic [31:0] INST_BEQ    = 32'h0000_0063;
  localparam logic [31:0] INST_JAL    = 32'h0000_006f;
  localparam logic [31:0] INST_HALT_M = 32'hF000_2013;

  typedef enum logic [1:0] {
    SEG_IDLE = 2'd0,
    SEG_RUN  = 2'd1,
    SEG_DONE = 2'd2
  } seg_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_GAP       = 3'd1,
    ERR_ORDER     = 3'd2,
    ERR_POST_HALT = 3'd3,
    ERR_TIMEOUT   = 3'd4
  } err_e;

  seg_e               seg_q, seg_d;
  err_e               code_q, code_d;
  logic               halt_q, halt_d;
  logic               error_q, error_d;
  logic [ORDER_W-1:0] exp_q, exp_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [CNT_W-1:0]   inst_cnt_q, inst_cnt_d;
  logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0]   total_q, total_d;

  logic [CHANNELS:0]   valid_ext;
  logic [CHANNELS-1:0] is_halt;
  logic [CHANNELS-1:0] eff_valid;
  logic                scan_open;
  logic                gap_hit, order_hit, halt_hit, post_halt_hit, tmo_hit;
  logic [VCNT_W-1:0]   eff_cnt;
  logic                seg_started;

  // Bit i is the valid of the channel below i; bit 0 is pinned high so channel 0 never gaps.
  assign valid_ext = {rvfi.valid, 1'b1};

  // Walk channels oldest-first, closing the effective set after the first halting
  // channel; once halted nothing is effective, so no counting or ordering happens.
  always_comb begin
    is_halt   = '0;
    eff_valid = '0;
    gap_hit   = 1'b0;
    order_hit = 1'b0;
    halt_hit  = 1'b0;
    eff_cnt   = '0;
    scan_open = ~halt_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      is_halt[i] = rvfi.valid[i] &&
                   ((rvfi.pc_rdata[i] == rvfi.pc_wdata[i]) ||
                    (rvfi.inst[i] == INST_BEQ) ||
                    (rvfi.inst[i] == INST_JAL) ||
                    (rvfi.inst[i] == INST_HALT_M));
      if (scan_open) begin
        if (rvfi.valid[i]) begin
          eff_valid[i] = 1'b1;
          if (rvfi.order[i] != exp_q + ORDER_W'(eff_cnt)) begin
            order_hit = 1'b1;
          end
          eff_cnt = eff_cnt + VCNT_W'(1);
        end
        if (rvfi.valid[i] && !valid_ext[i]) begin
          gap_hit = 1'b1;
        end
        if (is_halt[i]) begin
          halt_hit  = 1'b1;
          scan_open = 1'b0;
        end
      end
    end
  end

  // Segment FSM next state: markers are resolved in channel order so a start and
  // a stop in the same cycle bracket exactly the channels between them.
  always_comb begin
    seg_d       = seg_q;
    inst_cnt_d  = inst_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    seg_started = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (eff_valid[i]) begin
        if (rvfi.inst[i] == INST_START) begin
          seg_d       = SEG_RUN;
          inst_cnt_d  = '0;
          seg_started = 1'b1;
        end else if (seg_d == SEG_RUN) begin
          inst_cnt_d = inst_cnt_d + CNT_W'(1);
          if (rvfi.inst[i] == INST_STOP) begin
            seg_d = SEG_DONE;
          end
        end
      end
    end
    if (seg_started) begin
      cyc_cnt_d = '0;
    end else if (seg_q == SEG_RUN) begin
      cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    end
  end

  // Order tracking, commit total, watchdog and first-error capture.
  always_comb begin
    halt_d        = halt_q | halt_hit;
    exp_d         = exp_q + ORDER_W'(eff_cnt);
    total_d       = total_q + CNT_W'(eff_cnt);
    post_halt_hit = halt_q && (|rvfi.valid);
    idle_d        = idle_q;
    tmo_hit       = 1'b0;
    if (!halt_q) begin
      if (|rvfi.valid) begin
        idle_d = '0;
      end else if (idle_q != TIMEOUT_V) begin
        idle_d  = idle_q + IDLE_W'(1);
        tmo_hit = (idle_d == TIMEOUT_V);
      end
    end
    error_d = error_q;
    code_d  = code_q;
    if (!error_q) begin
      error_d = 1'b1;
      if (gap_hit)            code_d = ERR_GAP;
      else if (order_hit)     code_d = ERR_ORDER;
      else if (post_halt_hit) code_d = ERR_POST_HALT;
      else if (tmo_hit)       code_d = ERR_TIMEOUT;
      else                    error_d = 1'b0;
    end
  end

  // State registers with synchronous reset; rst-cycle inputs are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= SEG_IDLE;
      code_q     <= ERR_NONE;
      halt_q     <= 1'b0;
      error_q    <= 1'b0;
      exp_q      <= '0;
      idle_q     <= '0;
      inst_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      total_q    <= '0;
    end else begin
      seg_q      <= seg_d;
      code_q     <= code_d;
      halt_q     <= halt_d;
      error_q    <= error_d;
      exp_q      <= exp_d;
      idle_q     <= idle_d;
      inst_cnt_q <= inst_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      total_q    <= total_d;
    end
  end

  assign halt            = halt_q;
  assign error           = error_q;
  assign err_code        = code_q;
  assign seg_state       = seg_q;
  assign seg_inst_count  = inst_cnt_q;
  assign seg_cycle_count = cyc_cnt_q;
  assign commit_total    = total_q;

endmodule

// File: tb/tb_rvfi_commit_checker.sv
// Bench for rvfi_commit_checker: directed scenarios with literal expectations
// plus randomized retire traffic compared every cycle against a queue-based model.
module tb_rvfi_commit_checker;
  localparam int unsigned CH = 8;
  localparam int unsigned OW = 64;
  localparam int unsigned CW = 64;
  localparam int unsigned TO = 16;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] START = 32'h0010_2013;
  localparam logic [31:0] STOP  = 32'h0020_2013;

  logic          clk = 1'b0;
  logic          rst;
  logic          halt, error;
  logic [2:0]    err_code;
  logic [1:0]    seg_state;
  logic [CW-1:0] seg_inst_count, seg_cycle_count, commit_total;

  always #5 clk = ~clk;

  rvfi_commit_checker_if #(.CHANNELS(CH), .ORDER_W(OW)) rvfi ();

  rvfi_commit_checker #(
    .CHANNELS(CH),
    .ORDER_W (OW),
    .CNT_W   (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rvfi           (rvfi),
    .halt           (halt),
    .error          (error),
    .err_code       (err_code),
    .seg_state      (seg_state),
    .seg_inst_count (seg_inst_count),
    .seg_cycle_count(seg_cycle_count),
    .commit_total   (commit_total)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model state (seg: 0 idle, 1 run, 2 done)
  bit            m_halt, m_err;
  int            m_code, m_seg, m_idle;
  logic [CW-1:0] m_inst, m_cyc, m_total;
  logic [OW-1:0] m_E;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit halting(input int i);
    logic [31:0] w;
    w = rvfi.inst[i];
    return (rvfi.pc_rdata[i] == rvfi.pc_wdata[i]) ||
           (w == 32'h0000_0063) || (w == 32'h0000_006f) || (w == 32'hF000_2013);
  endfunction

  // One clock of the reference behaviour, applied to the inputs sampled at the edge.
  task automatic model_cycle();
    int          idx[$];
    int          h;
    int          code;
    int          seg_old;
    bit          gap, ord, ph, tmo, any, started, was_halt, hit;
    logic [31:0] w;
    if (rst) begin
      m_halt = 0; m_err = 0; m_code = 0; m_seg = 0; m_idle = 0;
      m_inst = '0; m_cyc = '0; m_total = '0; m_E = '0;
      return;
    end
    gap = 0; ord = 0; ph = 0; tmo = 0; started = 0; hit = 0;
    any      = (rvfi.valid != '0);
    was_halt = m_halt;
    seg_old  = m_seg;
    if (was_halt) begin
      ph = any;
    end else begin
      h = CH - 1;
      for (int i = 0; i < CH; i++) begin
        if (rvfi.valid[i] && halting(i)) begin
          h = i;
          hit = 1;
          break;
        end
      end
      for (int i = 0; i <= h; i++) begin
        if (rvfi.valid[i]) idx.push_back(i);
        if (i > 0 && rvfi.valid[i] && !rvfi.valid[i-1]) gap = 1;
      end
      foreach (idx[k]) if (rvfi.order[idx[k]] != m_E + OW'(k)) ord = 1;
      m_E     = m_E + OW'(idx.size());
      m_total = m_total + CW'(idx.size());
      if (hit) m_halt = 1;
      foreach (idx[k]) begin
        w = rvfi.inst[idx[k]];
        if (w == START) begin
          m_seg = 1; m_inst = '0; started = 1;
        end else if (m_seg == 1) begin
          m_inst = m_inst + 1;
          if (w == STOP) m_seg = 2;
        end
      end
      if (any) m_idle = 0;
      else if (m_idle < TO) begin
        m_idle++;
        if (m_idle == TO) tmo = 1;
      end
    end
    if (started) m_cyc = '0;
    else if (seg_old == 1) m_cyc = m_cyc + 1;
    if (!m_err) begin
      code = gap ? 1 : ord ? 2 : ph ? 3 : tmo ? 4 : 0;
      if (code != 0) begin
        m_err = 1;
        m_code = code;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("halt", halt, m_halt);
      chk("error", error, m_err);
      chk("err_code", err_code, m_code);
      chk("seg_state", seg_state, m_seg);
      chk("seg_inst_count", seg_inst_count, m_inst);
      chk("seg_cycle_count", seg_cycle_count, m_cyc);
      chk("commit_total", commit_total, m_total);
    end
  end

  task automatic step();
    @(posedge clk);
    model_cycle();
    cmp_en = 1'b1;
    #1;
  endtask

  task automatic clear_inputs();
    rvfi.valid = '0;
    for (int i = 0; i < CH; i++) begin
      rvfi.order[i]    = '0;
      rvfi.inst[i]     = NOP;
      rvfi.pc_rdata[i] = 32'h100 + 32'(i) * 4;
      rvfi.pc_wdata[i] = 32'h104 + 32'(i) * 4;
    end
  endtask

  task automatic set_ch(input int i, input logic [OW-1:0] ord, input logic [31:0] w);
    rvfi.valid[i] = 1'b1;
    rvfi.order[i] = ord;
    rvfi.inst[i]  = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_halt"}, halt, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_seg_state"}, seg_state, 0);
    chk({tag, "_seg_inst"}, seg_inst_count, 0);
    chk({tag, "_seg_cyc"}, seg_cycle_count, 0);
    chk({tag, "_total"}, commit_total, 0);
  endtask

  initial begin
    int          r, n, idle_pct;
    int          k;
    logic [7:0]  pat;
    rst = 1'b1;
    clear_inputs();

    // Counting and order continuity
    do_reset();
    chk_reset_values("rst0");
    for (int i = 0; i < 3; i++) set_ch(i, OW'(i), NOP);
    step();
    clear_inputs();
    for (int i = 0; i < 8; i++) set_ch(i, OW'(3 + i), NOP);
    step();
    clear_inputs();
    chk("count_total", commit_total, 11);
    chk("count_error", error, 0);

    // Gap
    do_reset();
    set_ch(0, 0, NOP);
    set_ch(2, 1, NOP);
    step();
    clear_inputs();
    chk("gap_error", error, 1);
    chk("gap_code", err_code, 1);

    // Order mismatch, then a later gap keeps the first code
    do_reset();
    set_ch(0, 0, NOP);
    set_ch(1, 1, NOP);
    set_ch(2, 3, NOP);
    step();
    clear_inputs();
    chk("order_code", err_code, 2);
    set_ch(0, 3, NOP);
    set_ch(2, 4, NOP);
    step();
    clear_inputs();
    chk("order_sticky_code", err_code, 2);

    // Segment accounting
    do_reset();
    for (int i = 0; i < 5; i++) set_ch(i, OW'(i), (i == 2) ? START : NOP);
    step();
    clear_inputs();
    chk("seg_start_state", seg_state, 1);
    chk("seg_start_inst", seg_inst_count, 2);
    chk("seg_start_cyc", seg_cycle_count, 0);
    repeat (4) step();
    for (int i = 0; i < 5; i++) set_ch(i, OW'(5 + i), (i == 3) ? STOP : NOP);
    step();
    clear_inputs();
    chk("seg_done_state", seg_state, 2);
    chk("seg_done_inst", seg_inst_count, 6);
    chk("seg_done_cyc", seg_cycle_count, 5);

    // Halt and post-halt commit
    do_reset();
    for (int i = 0; i < 4; i++) set_ch(i, OW'(i), (i == 1) ? 32'h0000_006f : NOP);
    step();
    clear_inputs();
    chk("halt_set", halt, 1);
    chk("halt_total", commit_total, 2);
    chk("halt_noerr", error, 0);
    set_ch(0, 2, NOP);
    step();
    clear_inputs();
    chk("posthalt_code", err_code, 3);
    chk("posthalt_total", commit_total, 2);

    // Watchdog boundary, then reset mid-error
    do_reset();
    repeat (TO - 1) step();
    chk("wdog_15_error", error, 0);
    step();
    chk("wdog_16_error", error, 1);
    chk("wdog_16_code", err_code, 4);
    for (int i = 0; i < 3; i++) set_ch(i, OW'(i), (i == 0) ? START : NOP);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    chk_reset_values("rst1");

    // Randomized traffic
    for (int ep = 0; ep < 24; ep++) begin
      do_reset();
      idle_pct = (ep % 3 == 0) ? 85 : 20;
      for (int c = 0; c < 80; c++) begin
        clear_inputs();
        r = $urandom_range(0, 99);
        if (r < idle_pct) begin
          pat = '0;
        end else if ($urandom_range(0, 99) < 5) begin
          pat = 8'($urandom);
        end else begin
          n = $urandom_range(1, CH);
          pat = 8'((9'd1 << n) - 9'd1);
        end
        k = 0;
        for (int i = 0; i < CH; i++) begin
          if (pat[i]) begin
            r = $urandom_range(0, 99);
            set_ch(i, m_E + OW'(k), (r < 6) ? START : (r < 12) ? STOP : NOP);
            k++;
            r = $urandom_range(0, 199);
            if (r == 0) rvfi.inst[i] = 32'h0000_0063;
            else if (r == 1) rvfi.inst[i] = 32'hF000_2013;
            else if (r == 2) rvfi.pc_wdata[i] = rvfi.pc_rdata[i];
            if ($urandom_range(0, 99) < 2) rvfi.order[i] = rvfi.order[i] + 1;
          end
        end
        step();
      end
    end

    clear_inputs();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
